// File: rtl/fixed_point_pkg.sv
// Shared constants for the FixedPointArithmetic subtractor.
// ALGORITHM selector strings are kept here so instantiating code can reuse them.
package fixed_point_pkg;

  localparam string ALG_BS_COMPLEMENT   = "BS_COMPLEMENT";
  localparam string ALG_RIPPLE_BORROW   = "RIPPLE_BORROW";
  localparam string ALG_CARRY_LOOKAHEAD = "CARRY_LOOKAHEAD";

  // Width of the carry-lookahead groups.
  localparam int unsigned CLA_GROUP_W = 4;

endpackage

// File: rtl/fixed_point_full_subtractor.sv
// 1-bit full-subtractor cell: d = x - y - bi, bo set when the cell borrows.
module fixed_point_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/fixed_point_subtract.sv
// N-bit subtractor c = a - b - carry_in (mod 2^N) with registered borrow-out.
// ALGORITHM picks one of three bit-exact combinational datapaths.
module fixed_point_subtract
  import fixed_point_pkg::*;
#(
  parameter int    N         = 32,
  parameter string ALGORITHM = ALG_BS_COMPLEMENT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] c,
  output logic         carry_out
);

  logic [N-1:0] diff;
  logic         borrow;

  if (N < 2) begin : g_bad_width
    $error("fixed_point_subtract: N must be >= 2 (got %0d)", N);
  end

  if (ALGORITHM == ALG_BS_COMPLEMENT) begin : g_bs_complement
    logic [N:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, ~carry_in};
    assign diff   = sum[N-1:0];
    assign borrow = ~sum[N];

  end else if (ALGORITHM == ALG_RIPPLE_BORROW) begin : g_ripple_borrow
    logic [N:0] chain;

    assign chain[0] = carry_in;

    for (genvar i = 0; i < N; i++) begin : g_cell
      fixed_point_full_subtractor u_cell (
        .x  (a[i]),
        .y  (b[i]),
        .bi (chain[i]),
        .d  (diff[i]),
        .bo (chain[i+1])
      );
    end

    assign borrow = chain[N];

  end else if (ALGORITHM == ALG_CARRY_LOOKAHEAD) begin : g_carry_lookahead
    localparam int unsigned GW = CLA_GROUP_W;
    localparam int unsigned G  = (N + GW - 1) / GW;

    logic [N-1:0] nb;
    logic [G-1:0] grp_g;
    logic [G-1:0] grp_p;
    logic [G:0]   grp_c;

    assign nb = ~b;

    for (genvar g = 0; g < G; g++) begin : g_group
      localparam int unsigned LO = g * GW;
      // Top group is narrower when N is not a multiple of the group width.
      localparam int unsigned W  = ((N - LO) > GW) ? GW : (N - LO);

      logic [W-1:0] bit_g;
      logic [W-1:0] bit_p;
      logic [W-1:0] bit_s;
      logic         gg;
      logic         gp;

      assign bit_g = a[LO +: W] & nb[LO +: W];
      assign bit_p = a[LO +: W] ^ nb[LO +: W];

      always_comb begin
        gg = 1'b0;
        gp = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
          gg = bit_g[i] | (bit_p[i] & gg);
          gp = gp & bit_p[i];
        end
      end

      // Sum bits kept separate from gg/gp so the group carry does not loop back.
      always_comb begin
        logic cc;
        cc    = grp_c[g];
        bit_s = '0;
        for (int unsigned i = 0; i < W; i++) begin
          bit_s[i] = bit_p[i] ^ cc;
          cc       = bit_g[i] | (bit_p[i] & cc);
        end
      end

      assign grp_g[g]       = gg;
      assign grp_p[g]       = gp;
      assign diff[LO +: W]  = bit_s;
    end

    always_comb begin
      grp_c    = '0;
      grp_c[0] = ~carry_in;
      for (int unsigned k = 0; k < G; k++) begin
        grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
    end

    assign borrow = ~grp_c[G];

  end else begin : g_bad_algorithm
    $error("fixed_point_subtract: unknown ALGORITHM \"%s\"", ALGORITHM);
    assign diff   = '0;
    assign borrow = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      carry_out <= 1'b0;
    end else begin
      c         <= diff;
      carry_out <= borrow;
    end
  end

endmodule

// File: tb/tb_fixed_point_subtract.sv
// Bench for fixed_point_subtract: all three datapaths at N=32 plus CLA at N=30,
// directed vectors, asynchronous reset, and a random back-to-back stream.
module tb_fixed_point_subtract;
  import fixed_point_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;

  logic [31:0] c_bs,  c_rb,  c_cla;
  logic [29:0] c_cla30;
  logic        co_bs, co_rb, co_cla, co_cla30;

  int checks   = 0;
  int failures = 0;

  fixed_point_subtract #(.N(32), .ALGORITHM(ALG_BS_COMPLEMENT)) u_bs (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .carry_in(carry_in),
    .c(c_bs), .carry_out(co_bs)
  );

  fixed_point_subtract #(.N(32), .ALGORITHM(ALG_RIPPLE_BORROW)) u_rb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .carry_in(carry_in),
    .c(c_rb), .carry_out(co_rb)
  );

  fixed_point_subtract #(.N(32), .ALGORITHM(ALG_CARRY_LOOKAHEAD)) u_cla (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .carry_in(carry_in),
    .c(c_cla), .carry_out(co_cla)
  );

  fixed_point_subtract #(.N(30), .ALGORITHM(ALG_CARRY_LOOKAHEAD)) u_cla30 (
    .clk(clk), .rst_n(rst_n), .a(a[29:0]), .b(b[29:0]), .carry_in(carry_in),
    .c(c_cla30), .carry_out(co_cla30)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact integer D = a - b - ci over n-bit unsigned operands; {borrow, D mod 2^n}.
  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input int n);
    longint mask;
    longint d;
    logic [32:0] r;
    mask     = (longint'(1) << n) - 1;
    d        = (longint'(x) & mask) - (longint'(y) & mask) - longint'(ci);
    r        = '0;
    r[31:0]  = 32'(d & mask);
    r[32]    = (d < 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got carry_out=%0b c=0x%08h, expected carry_out=%0b c=0x%08h",
               name, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic check_all(input string tag, input logic [32:0] exp32, input logic [32:0] exp30);
    check({tag, "/bs"},    {co_bs,    c_bs},           exp32);
    check({tag, "/rb"},    {co_rb,    c_rb},           exp32);
    check({tag, "/cla"},   {co_cla,   c_cla},          exp32);
    check({tag, "/cla30"}, {co_cla30, 2'b00, c_cla30}, exp30);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] exp_c;
    logic        exp_co;
  } vec_t;

  vec_t vecs[6];

  logic [32:0] pend32[$];
  logic [32:0] pend30[$];

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};

    rst_n    = 1'b0;
    a        = 32'h1234_5678;
    b        = 32'h0000_0001;
    carry_in = 1'b0;
    #2;
    check_all("reset", 33'd0, 33'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a        = vecs[i].a;
      b        = vecs[i].b;
      carry_in = vecs[i].ci;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), {vecs[i].exp_co, vecs[i].exp_c},
                ref_sub(vecs[i].a, vecs[i].b, vecs[i].ci, 30));
    end

    // Asynchronous reset pulse between edges, then recovery on the next edge.
    @(negedge clk);
    a        = 32'd5;
    b        = 32'd3;
    carry_in = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 33'd0, 33'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_reset", 33'd2, 33'd2);

    // Back-to-back random stream, each vector checked one edge after it is applied.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case (i % 16)
        0: rb = ra;
        1: rb = ra + 32'd1;
        2: ra = '0;
        3: rb = '1;
        default: ;
      endcase
      a        = ra;
      b        = rb;
      carry_in = rc;
      pend32.push_back(ref_sub(ra, rb, rc, 32));
      pend30.push_back(ref_sub(ra, rb, rc, 30));
      @(posedge clk);
      #1;
      check_all("random", pend32.pop_front(), pend30.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
